// File: rtl/fix_msg_serializer.sv
// Serializes one outbound FIX session message (logon, logout, heartbeat, resend request)
// as an ASCII byte stream with BodyLength(9) and CheckSum(10) generated on the fly.
module fix_msg_serializer #(
  parameter int unsigned VALUE_WIDTH = 64,
  parameter int unsigned SIZE        = 4,
  parameter int unsigned SEQ_WIDTH   = 20,
  parameter logic [63:0] SENDER_ID   = 64'h5352560000000000,
  parameter int unsigned SENDER_LEN  = 3,
  parameter int unsigned HB_INT      = 30
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [3:0]             msg_type_i,
  input  logic [VALUE_WIDTH-1:0] target_id_i,
  input  logic [SIZE-1:0]        target_size_i,
  input  logic [SEQ_WIDTH-1:0]   seq_num_i,
  input  logic [SEQ_WIDTH-1:0]   begin_seq_i,
  output logic [7:0]             tx_data_o,
  output logic                   tx_valid_o,
  input  logic                   tx_ready_i,
  output logic                   tx_last_o,
  output logic                   busy_o,
  output logic                   err_o
);

  localparam int unsigned CW = 24;
  localparam logic [7:0] Soh = 8'h01;
  localparam logic [7:0] HbTens = 8'(48 + HB_INT / 10);
  localparam logic [7:0] HbOnes = 8'(48 + HB_INT % 10);
  localparam logic [95:0] BeginStr = {"8=FIX.4.2", Soh, 16'h0};
  localparam logic [95:0] HbStr = {"98=0", Soh, "108=", HbTens, HbOnes, Soh};
  localparam logic [3:0] SndEnd = 4'(3 + SENDER_LEN);
  // "35=" + type + SOH, plus the fixed overhead of the sender, target and seq fields
  localparam logic [5:0] LenFixed = 6'(5 + SENDER_LEN + 4 + 4 + 4);

  typedef enum logic [1:0] {StIdle, StConv, StEmit} state_e;
  typedef enum logic [3:0] {
    SegBegin, SegLen, SegType, SegSender, SegTarget, SegSeq, SegHb, SegBeg, SegGap, SegSum
  } seg_e;

  function automatic logic [7:0] pick(input logic [95:0] s, input logic [3:0] p);
    logic [7:0] b;
    b = 8'h00;
    for (int i = 0; i < 12; i++) begin
      if (p == 4'(i)) b = s[95-8*i -: 8];
    end
    return b;
  endfunction

  function automatic logic [7:0] tgt_byte(input logic [VALUE_WIDTH-1:0] v, input logic [3:0] p);
    logic [7:0] b;
    b = 8'h00;
    for (int i = 0; i < VALUE_WIDTH / 8; i++) begin
      if (p == 4'(i)) b = v[VALUE_WIDTH-1-8*i -: 8];
    end
    return b;
  endfunction

  function automatic logic [CW-1:0] pow10(input logic [2:0] k);
    logic [CW-1:0] r;
    case (k)
      3'd0:    r = CW'(1);
      3'd1:    r = CW'(10);
      3'd2:    r = CW'(100);
      3'd3:    r = CW'(1000);
      3'd4:    r = CW'(10000);
      3'd5:    r = CW'(100000);
      default: r = CW'(1000000);
    endcase
    return r;
  endfunction

  function automatic logic [2:0] num_digits(input logic [6:0][3:0] d);
    logic [2:0] n;
    n = 3'd1;
    for (int i = 1; i < 7; i++) begin
      if (d[i] != 4'd0) n = 3'(i + 1);
    end
    return n;
  endfunction

  function automatic logic [7:0] type_char(input logic [3:0] t);
    logic [7:0] c;
    case (t)
      4'd1:    c = 8'h41;
      4'd2:    c = 8'h35;
      4'd3:    c = 8'h30;
      4'd4:    c = 8'h32;
      default: c = 8'h3f;
    endcase
    return c;
  endfunction

  state_e                    state_q, state_d;
  seg_e                      seg_q, seg_d, seg_next;
  logic [3:0]                type_q, type_d;
  logic [VALUE_WIDTH-1:0]    target_q, target_d;
  logic [SIZE-1:0]           tsize_q, tsize_d;
  // Index 0 converts MsgSeqNum, index 1 converts BeginSeqNo; both run in parallel
  logic [1:0][CW-1:0]        rem_q, rem_d;
  logic [1:0][2:0]           k_q, k_d;
  logic [1:0]                done_q, done_d;
  logic [1:0][6:0][3:0]      dig_q, dig_d;
  logic [5:0]                len_q, len_d;
  logic [3:0]                pos_q, pos_d;
  logic [7:0]                sum_q, sum_d;
  logic                      err_q, err_d;

  logic [2:0] nd_s, nd_b, di_s, di_b;
  logic [3:0] seg_len, tgt_end;
  logic [7:0] byte_val, len_t, len_o, c_h, c_t, c_o;
  logic [5:0] extra_len;

  assign nd_s    = num_digits(dig_q[0]);
  assign nd_b    = num_digits(dig_q[1]);
  // Digit positions counted from the least significant; wraps harmlessly in 3 bits
  assign di_s    = nd_s + 3'd2 - pos_q[2:0];
  assign di_b    = nd_b + 3'd1 - pos_q[2:0];
  assign tgt_end = 4'(tsize_q) + 4'd3;
  assign len_t   = 8'h30 + {2'b00, len_q / 6'd10};
  assign len_o   = 8'h30 + {2'b00, len_q % 6'd10};
  assign c_h     = 8'h30 + sum_q / 8'd100;
  assign c_t     = 8'h30 + (sum_q / 8'd10) % 8'd10;
  assign c_o     = 8'h30 + sum_q % 8'd10;

  always_comb begin
    extra_len = 6'd0;
    if (type_q == 4'd1) extra_len = 6'd12;
    else if (type_q == 4'd4) extra_len = {3'b000, nd_b} + 6'd8;
  end

  always_comb begin
    byte_val = 8'h00;
    seg_len  = 4'd1;
    seg_next = SegSum;
    unique case (seg_q)
      SegBegin: begin
        seg_len  = 4'd10;
        byte_val = pick(BeginStr, pos_q);
        seg_next = SegLen;
      end
      SegLen: begin
        seg_len  = 4'd5;
        byte_val = pick({"9=", len_t, len_o, Soh, 56'h0}, pos_q);
        seg_next = SegType;
      end
      SegType: begin
        seg_len  = 4'd5;
        byte_val = pick({"35=", type_char(type_q), Soh, 56'h0}, pos_q);
        seg_next = SegSender;
      end
      SegSender: begin
        seg_len  = SndEnd + 4'd1;
        seg_next = SegTarget;
        if (pos_q < 4'd3)        byte_val = pick({"49=", 72'h0}, pos_q);
        else if (pos_q < SndEnd) byte_val = pick({SENDER_ID, 32'h0}, pos_q - 4'd3);
        else                     byte_val = Soh;
      end
      SegTarget: begin
        seg_len  = tgt_end + 4'd1;
        seg_next = SegSeq;
        if (pos_q < 4'd3)         byte_val = pick({"56=", 72'h0}, pos_q);
        else if (pos_q < tgt_end) byte_val = tgt_byte(target_q, pos_q - 4'd3);
        else                      byte_val = Soh;
      end
      SegSeq: begin
        seg_len = {1'b0, nd_s} + 4'd4;
        if (type_q == 4'd1)      seg_next = SegHb;
        else if (type_q == 4'd4) seg_next = SegBeg;
        else                     seg_next = SegSum;
        if (pos_q < 4'd3)                        byte_val = pick({"34=", 72'h0}, pos_q);
        else if (pos_q < {1'b0, nd_s} + 4'd3)    byte_val = {4'h3, dig_q[0][di_s]};
        else                                     byte_val = Soh;
      end
      SegHb: begin
        seg_len  = 4'd12;
        byte_val = pick(HbStr, pos_q);
        seg_next = SegSum;
      end
      SegBeg: begin
        seg_len  = {1'b0, nd_b} + 4'd3;
        seg_next = SegGap;
        if (pos_q < 4'd2)                        byte_val = pick({"7=", 80'h0}, pos_q);
        else if (pos_q < {1'b0, nd_b} + 4'd2)    byte_val = {4'h3, dig_q[1][di_b]};
        else                                     byte_val = Soh;
      end
      SegGap: begin
        seg_len  = 4'd5;
        byte_val = pick({"16=0", Soh, 56'h0}, pos_q);
        seg_next = SegSum;
      end
      SegSum: begin
        seg_len  = 4'd7;
        byte_val = pick({"10=", c_h, c_t, c_o, Soh, 40'h0}, pos_q);
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    type_d   = type_q;
    target_d = target_q;
    tsize_d  = tsize_q;
    rem_d    = rem_q;
    k_d      = k_q;
    done_d   = done_q;
    dig_d    = dig_q;
    len_d    = len_q;
    seg_d    = seg_q;
    pos_d    = pos_q;
    sum_d    = sum_q;
    err_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          type_d   = msg_type_i;
          target_d = target_id_i;
          tsize_d  = target_size_i;
          rem_d[0] = CW'(seq_num_i);
          rem_d[1] = CW'(begin_seq_i);
          k_d      = {3'd6, 3'd6};
          done_d   = 2'b00;
          dig_d    = '0;
          sum_d    = 8'h00;
          if (msg_type_i != 4'd0 && msg_type_i <= 4'd4) state_d = StConv;
          else                                          err_d   = 1'b1;
        end
      end
      StConv: begin
        // One subtract of 10^k or one step down to k-1 per cycle
        for (int c = 0; c < 2; c++) begin
          if (!done_q[c[0]]) begin
            if (rem_q[c[0]] >= pow10(k_q[c[0]])) begin
              rem_d[c[0]]             = rem_q[c[0]] - pow10(k_q[c[0]]);
              dig_d[c[0]][k_q[c[0]]]  = dig_q[c[0]][k_q[c[0]]] + 4'd1;
            end else if (k_q[c[0]] == 3'd0) begin
              done_d[c[0]] = 1'b1;
            end else begin
              k_d[c[0]] = k_q[c[0]] - 3'd1;
            end
          end
        end
        if (&done_q) begin
          len_d   = LenFixed + 6'(tsize_q) + {3'b000, nd_s} + extra_len;
          seg_d   = SegBegin;
          pos_d   = 4'd0;
          state_d = StEmit;
        end
      end
      StEmit: begin
        if (tx_ready_i) begin
          if (seg_q != SegSum) sum_d = sum_q + byte_val;
          if (pos_q == seg_len - 4'd1) begin
            pos_d = 4'd0;
            if (seg_q == SegSum) state_d = StIdle;
            else                 seg_d   = seg_next;
          end else begin
            pos_d = pos_q + 4'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      seg_q    <= SegBegin;
      type_q   <= 4'd0;
      target_q <= '0;
      tsize_q  <= '0;
      rem_q    <= '0;
      k_q      <= '0;
      done_q   <= 2'b00;
      dig_q    <= '0;
      len_q    <= 6'd0;
      pos_q    <= 4'd0;
      sum_q    <= 8'h00;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      seg_q    <= seg_d;
      type_q   <= type_d;
      target_q <= target_d;
      tsize_q  <= tsize_d;
      rem_q    <= rem_d;
      k_q      <= k_d;
      done_q   <= done_d;
      dig_q    <= dig_d;
      len_q    <= len_d;
      pos_q    <= pos_d;
      sum_q    <= sum_d;
      err_q    <= err_d;
    end
  end

  assign req_ready_o = (state_q == StIdle);
  assign busy_o      = (state_q != StIdle);
  assign tx_valid_o  = (state_q == StEmit);
  assign tx_data_o   = (state_q == StEmit) ? byte_val : 8'h00;
  assign tx_last_o   = (state_q == StEmit) && (seg_q == SegSum) && (pos_q == 4'd6);
  assign err_o       = err_q;

endmodule

// File: tb/tb_fix_msg_serializer.sv
// Bench for fix_msg_serializer: a string-level message model feeds an expected-byte queue that
// a per-cycle monitor drains, plus literal message checks.
module tb_fix_msg_serializer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [3:0]  msg_type_i;
  logic [63:0] target_id_i;
  logic [3:0]  target_size_i;
  logic [19:0] seq_num_i;
  logic [19:0] begin_seq_i;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i;
  logic        tx_last_o;
  logic        busy_o;
  logic        err_o;

  int checks = 0;
  int errors = 0;
  int msgs_done = 0;
  bit stall_mode = 1'b0;
  logic [7:0] exp_q[$];
  bit         exp_last_q[$];
  logic [7:0] rx_q[$];

  always #5 clk = ~clk;

  fix_msg_serializer dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .msg_type_i    (msg_type_i),
    .target_id_i   (target_id_i),
    .target_size_i (target_size_i),
    .seq_num_i     (seq_num_i),
    .begin_seq_i   (begin_seq_i),
    .tx_data_o     (tx_data_o),
    .tx_valid_o    (tx_valid_o),
    .tx_ready_i    (tx_ready_i),
    .tx_last_o     (tx_last_o),
    .busy_o        (busy_o),
    .err_o         (err_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  task automatic check_str(input string name, input string act, input string want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s: got \"%s\" expected \"%s\"", name, act, want);
    end
  endtask

  function automatic string rx_str();
    string r;
    r = "";
    foreach (rx_q[i]) r = $sformatf("%s%c", r, (rx_q[i] == 8'h01) ? 8'h7c : rx_q[i]);
    return r;
  endfunction

  function automatic bit has(input string s, input string p);
    for (int i = 0; i + p.len() <= s.len(); i++) begin
      if (s.substr(i, i + p.len() - 1) == p) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Whole message as a string with '|' for SOH, then flattened into the expected queue
  task automatic build_model(input logic [3:0] t, input string tgt, input int seq, input int beg);
    string tc, body, msg;
    int sum;
    case (t)
      4'd1:    tc = "A";
      4'd2:    tc = "5";
      4'd3:    tc = "0";
      default: tc = "2";
    endcase
    body = $sformatf("35=%s|49=SRV|56=%s|34=%0d|", tc, tgt, seq);
    if (t == 4'd1) body = {body, "98=0|108=30|"};
    if (t == 4'd4) body = {body, $sformatf("7=%0d|16=0|", beg)};
    msg = {$sformatf("8=FIX.4.2|9=%0d|", body.len()), body};
    sum = 0;
    for (int i = 0; i < msg.len(); i++) sum += (msg[i] == 8'h7c) ? 1 : int'(msg[i]);
    msg = {msg, $sformatf("10=%03d|", sum % 256)};
    for (int i = 0; i < msg.len(); i++) begin
      exp_q.push_back((msg[i] == 8'h7c) ? 8'h01 : msg[i]);
      exp_last_q.push_back(i == msg.len() - 1);
    end
  endtask

  task automatic send_req(input logic [3:0] t, input string tgt, input int seq, input int beg);
    logic [63:0] tid;
    int n;
    tid = '0;
    for (int i = 0; i < tgt.len(); i++) tid[63-8*i -: 8] = tgt[i];
    @(posedge clk);
    #1;
    req_valid_i   = 1'b1;
    msg_type_i    = t;
    target_id_i   = tid;
    target_size_i = 4'(tgt.len());
    seq_num_i     = 20'(seq);
    begin_seq_i   = 20'(beg);
    n = 0;
    @(negedge clk);
    while (!req_ready_o && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("req_accept", {31'd0, req_ready_o}, 32'd1);
    check("prior_msg_done", exp_q.size(), 0);
    if (t >= 4'd1 && t <= 4'd4) begin
      rx_q.delete();
      build_model(t, tgt, seq, beg);
    end
    @(posedge clk);
    #1;
    // Scramble inputs: the accepted request must already be captured
    req_valid_i   = 1'b0;
    msg_type_i    = 4'd0;
    target_id_i   = 64'h4444444444444444;
    target_size_i = 4'd8;
    seq_num_i     = 20'd999;
    begin_seq_i   = 20'd888;
  endtask

  task automatic wait_msgs(input int target);
    int n;
    n = 0;
    while (msgs_done < target && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("msg_complete", {31'd0, msgs_done >= target}, 32'd1);
  endtask

  task automatic monitor();
    logic [7:0] held_d, e;
    logic held_l, l;
    bit held, in_msg;
    held = 1'b0;
    in_msg = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_msg = 1'b0;
        held = 1'b0;
      end else begin
        check("ready_vs_busy", {31'd0, req_ready_o}, {31'd0, !busy_o});
        if (in_msg) check("no_gap", {31'd0, tx_valid_o}, 32'd1);
        if (held) begin
          check("stall_data", {24'd0, tx_data_o}, {24'd0, held_d});
          check("stall_last", {31'd0, tx_last_o}, {31'd0, held_l});
        end
        held = 1'b0;
        if (tx_valid_o) begin
          in_msg = 1'b1;
          if (tx_ready_i) begin
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_byte: got %0h expected no transfer", tx_data_o);
            end else begin
              e = exp_q.pop_front();
              l = exp_last_q.pop_front();
              check("tx_data", {24'd0, tx_data_o}, {24'd0, e});
              check("tx_last", {31'd0, tx_last_o}, {31'd0, l});
            end
            rx_q.push_back(tx_data_o);
            if (tx_last_o) begin
              in_msg = 1'b0;
              msgs_done++;
            end
          end else begin
            held   = 1'b1;
            held_d = tx_data_o;
            held_l = tx_last_o;
          end
        end
      end
    end
  endtask

  task automatic drive_ready();
    forever begin
      @(posedge clk);
      #1;
      tx_ready_i = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  endtask

  initial begin
    int target, n;
    req_valid_i   = 1'b0;
    msg_type_i    = 4'd0;
    target_id_i   = '0;
    target_size_i = '0;
    seq_num_i     = '0;
    begin_seq_i   = '0;
    tx_ready_i    = 1'b1;
    fork
      monitor();
      drive_ready();
    join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", {31'd0, req_ready_o}, 32'd1);
    check("rst_tx_valid", {31'd0, tx_valid_o}, 32'd0);
    check("rst_tx_last", {31'd0, tx_last_o}, 32'd0);
    check("rst_tx_data", {24'd0, tx_data_o}, 32'd0);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_err", {31'd0, err_o}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", {31'd0, req_ready_o}, 32'd1);

    // Heartbeat, fully hand-computed (checksum 2005 mod 256 = 213)
    target = msgs_done + 1;
    send_req(4'd3, "CLI", 7, 0);
    wait_msgs(target);
    check("hb_size", rx_q.size(), 46);
    check_str("hb_msg", rx_str(), "8=FIX.4.2|9=24|35=0|49=SRV|56=CLI|34=7|10=213|");

    // Logon
    target = msgs_done + 1;
    send_req(4'd1, "CLI", 1, 0);
    wait_msgs(target);
    check("logon_size", rx_q.size(), 58);
    check_str("logon_prefix", rx_str().substr(0, 50),
              "8=FIX.4.2|9=36|35=A|49=SRV|56=CLI|34=1|98=0|108=30|");

    // Resend requests
    target = msgs_done + 1;
    send_req(4'd4, "CLIENT01", 12, 5);
    wait_msgs(target);
    check_str("resend_len", rx_str().substr(10, 14), "9=39|");
    check("resend_body", {31'd0, has(rx_str(), "56=CLIENT01|34=12|7=5|16=0|10=")}, 32'd1);
    target = msgs_done + 1;
    send_req(4'd4, "X", 1048575, 999999);
    wait_msgs(target);
    check("resend_max", {31'd0, has(rx_str(), "|34=1048575|7=999999|16=0|10=")}, 32'd1);
    target = msgs_done + 1;
    send_req(4'd2, "CLI", 0, 0);
    wait_msgs(target);
    check("zero_seq", {31'd0, has(rx_str(), "|35=5|49=SRV|56=CLI|34=0|10=")}, 32'd1);

    // Backpressure: logout stalled randomly, heartbeat held pending behind it
    stall_mode = 1'b1;
    target = msgs_done + 2;
    send_req(4'd2, "CLI", 123, 0);
    send_req(4'd3, "CLI", 124, 0);
    wait_msgs(target);
    stall_mode = 1'b0;

    // Unsupported type
    send_req(4'd9, "CLI", 5, 0);
    @(negedge clk);
    check("bad_err_pulse", {31'd0, err_o}, 32'd1);
    check("bad_no_valid", {31'd0, tx_valid_o}, 32'd0);
    check("bad_ready", {31'd0, req_ready_o}, 32'd1);
    @(negedge clk);
    check("bad_err_clear", {31'd0, err_o}, 32'd0);
    check("bad_no_valid2", {31'd0, tx_valid_o}, 32'd0);

    // Reset in the middle of a message
    target = msgs_done;
    send_req(4'd3, "CLI", 7, 0);
    n = 0;
    while (rx_q.size() < 20 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("mid_reached", {31'd0, rx_q.size() >= 20}, 32'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    exp_q.delete();
    exp_last_q.delete();
    rx_q.delete();
    @(negedge clk);
    check("mid_rst_valid", {31'd0, tx_valid_o}, 32'd0);
    check("mid_rst_ready", {31'd0, req_ready_o}, 32'd1);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("mid_post_ready", {31'd0, req_ready_o}, 32'd1);
    check("mid_post_valid", {31'd0, tx_valid_o}, 32'd0);
    check("mid_abandoned", msgs_done, target);
    target = msgs_done + 1;
    send_req(4'd3, "CLI", 7, 0);
    wait_msgs(target);
    check_str("hb_after_rst", rx_str(), "8=FIX.4.2|9=24|35=0|49=SRV|56=CLI|34=7|10=213|");
    check("exp_drained", exp_q.size(), 0);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
